// File: rtl/uart_rsp_tx.sv
// uart_rsp_tx: frames a tagged 16-bit response as '!', tag, data hi, data lo and sends it 8N1, LSB first.
// Latency: start bit begins on the accepting edge; rsp_done pulses 40*CLKS_PER_BIT cycles later.
// Backpressure: rsp_ready is high only while idle; the source holds rsp_valid until accepted.
module uart_rsp_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] MGU_TAG      = 8'h4D,
    parameter logic [7:0] GNU_TAG      = 8'h47
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rsp_valid,
    input  logic        rsp_sel,
    input  logic [15:0] rsp_data,
    output logic        rsp_ready,
    output logic        oData,
    output logic        tx_active,
    output logic        rsp_done
);
    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   frame;
    logic [7:0]    cur_byte;
    logic [2:0]    nxt_bit;
    logic          bit_end;

    // byte 0 ('!') sits in the top byte of the frame register
    always_comb begin
        cur_byte = frame[{~byte_idx, 3'b000} +: 8];
        nxt_bit  = bit_idx + 3'd1;
        bit_end  = (clk_cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            frame     <= '0;
            rsp_ready <= 1'b0;
            oData     <= 1'b1;
            tx_active <= 1'b0;
            rsp_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oData     <= 1'b1;
                    tx_active <= 1'b0;
                    rsp_done  <= 1'b0;
                    clk_cnt   <= '0;
                    if (rsp_valid && rsp_ready) begin
                        frame     <= {8'h21, (rsp_sel ? GNU_TAG : MGU_TAG), rsp_data};
                        byte_idx  <= 2'd0;
                        state     <= START;
                        oData     <= 1'b0;
                        tx_active <= 1'b1;
                        rsp_ready <= 1'b0;
                    end else begin
                        rsp_ready <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        oData   <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            oData <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= nxt_bit;
                            oData   <= cur_byte[nxt_bit];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            oData     <= 1'b1;
                            tx_active <= 1'b0;
                            rsp_done  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            oData    <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    rsp_done  <= 1'b0;
                    oData     <= 1'b1;
                    tx_active <= 1'b0;
                    rsp_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    oData     <= 1'b1;
                    tx_active <= 1'b0;
                    rsp_done  <= 1'b0;
                    rsp_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rsp_tx.sv
// Bench for uart_rsp_tx: a driver queues expected frames on acceptance, a monitor decodes the line.
module tb_uart_rsp_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rsp_valid, rsp_sel, rsp_ready, oData, tx_active, rsp_done;
    logic [15:0] rsp_data;
    logic        v2, s2, r2, l2, a2, dn2;
    logic [15:0] d2;
    logic        v3, s3, r3, l3, a3, dn3;
    logic [15:0] d3;

    uart_rsp_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rsp_valid(rsp_valid), .rsp_sel(rsp_sel),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .oData(oData),
        .tx_active(tx_active), .rsp_done(rsp_done));

    uart_rsp_tx #(.CLKS_PER_BIT(2)) dut_min (
        .clk(clk), .rst_n(rst_n), .rsp_valid(v2), .rsp_sel(s2),
        .rsp_data(d2), .rsp_ready(r2), .oData(l2),
        .tx_active(a2), .rsp_done(dn2));

    uart_rsp_tx #(.CLKS_PER_BIT(434)) dut_slow (
        .clk(clk), .rst_n(rst_n), .rsp_valid(v3), .rsp_sel(s3),
        .rsp_data(d3), .rsp_ready(r3), .oData(l3),
        .tx_active(a3), .rsp_done(dn3));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_sent = 0;
    int frames_seen = 0;
    int last_done_cyc = 0;
    int last_gap = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic sel, input logic [15:0] d);
        return {8'h21, (sel ? 8'h47 : 8'h4D), d};
    endfunction

    // Line level of serial bit j (0..39) of a frame: start 0, data LSB first, stop 1.
    function automatic logic exp_bit(input logic [31:0] f, input int j);
        logic [7:0] by;
        int p;
        by = 8'(f >> (8 * (3 - j / 10)));
        p  = j % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p - 1];
    endfunction

    // {line, tx_active, rsp_ready, rsp_done} of instance w
    function automatic logic [3:0] outs(input int w);
        case (w)
            1:       return {oData, tx_active, rsp_ready, rsp_done};
            2:       return {l2, a2, r2, dn2};
            default: return {l3, a3, r3, dn3};
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic s, input logic [15:0] d);
        if (w == 2) begin v2 = v; s2 = s; d2 = d; end
        else begin v3 = v; s3 = s; d3 = d; end
    endtask

    // Entered at the negedge of the first start-bit cycle.
    task automatic check_frame(input int w, input int cpb, input logic [31:0] f, output bit ab);
        int errs;
        int j;
        logic [31:0] got;
        logic [3:0] o;
        errs = 0;
        got  = '0;
        ab   = 1'b0;
        for (int c = 0; c < 40 * cpb; c++) begin
            if (c > 0) @(negedge clk);
            if (!rst_n) begin ab = 1'b1; return; end
            o = outs(w);
            j = c / cpb;
            if (o !== {exp_bit(f, j), 3'b100}) errs++;
            if (c % cpb == cpb / 2 && j % 10 >= 1 && j % 10 <= 8)
                got[8 * (3 - j / 10) + j % 10 - 1] = o[3];
        end
        @(negedge clk);
        if (!rst_n) begin ab = 1'b1; return; end
        chk("line_bits", errs, 0);
        chk("decoded_frame", got, f);
        chk("done_pulse", outs(w), 4'b1001);
        if (w == 1) last_done_cyc = cyc;
        @(negedge clk);
        chk("ready_after_done", outs(w), 4'b1010);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic sel, input logic [15:0] data, input bit keep_valid);
        int b;
        rsp_valid = 1'b1;
        rsp_sel   = sel;
        rsp_data  = data;
        b = 0;
        while (!rsp_ready && b < 1000) begin @(negedge clk); b++; end
        if (!rsp_ready) begin
            chk("accept_timeout", 0, 1);
            rsp_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(sel, data));
        n_sent++;
        @(negedge clk);
        chk("accept_latency", {oData, tx_active, rsp_ready}, 3'b010);
        if (!keep_valid) rsp_valid = 1'b0;
        rsp_sel  = 1'($urandom);
        rsp_data = 16'($urandom);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((frames_seen != n_sent || exp_q.size() != 0) && b < 5000) begin
            @(negedge clk);
            b++;
        end
        chk("drain", frames_seen, n_sent);
        repeat (3) @(negedge clk);
    endtask

    task automatic solo(input int w, input int cpb, input logic s, input logic [15:0] d);
        int b;
        bit ab;
        logic [3:0] o;
        @(negedge clk);
        drive(w, 1'b1, s, d);
        b = 0;
        o = outs(w);
        while (!o[1] && b < 100) begin @(negedge clk); b++; o = outs(w); end
        chk("solo_ready", o[1], 1);
        @(negedge clk);
        drive(w, 1'b0, ~s, ~d);
        check_frame(w, cpb, model(s, d), ab);
        chk("solo_no_abort", ab, 0);
    endtask

    // Monitor for the main instance
    initial begin : monitor
        bit ab;
        logic [31:0] f;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && oData === 1'b0) begin
                last_gap = cyc - last_done_cyc;
                chk("frame_expected", (exp_q.size() > 0), 1);
                f = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                check_frame(1, CPB, f, ab);
                if (!ab) frames_seen++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        int errs;
        rst_n = 1'b1;
        rsp_valid = 1'b0; rsp_sel = 1'b0; rsp_data = 16'h0;
        v2 = 1'b0; s2 = 1'b0; d2 = 16'h0;
        v3 = 1'b0; s3 = 1'b0; d3 = 16'h0;
        #1 rst_n = 1'b0;
        rsp_valid = 1'b1;
        #1 chk("reset_async", {oData, tx_active, rsp_ready, rsp_done}, 4'b1000);
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if ({oData, tx_active, rsp_ready, rsp_done} !== 4'b1000) errs++;
        end
        chk("reset_hold", errs, 0);
        rsp_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("ready_waits_edge", rsp_ready, 0);
        @(negedge clk);
        chk("ready_after_release", rsp_ready, 1);

        send(1'b0, 16'hF128, 1'b0);
        wait_idle();

        send(1'b1, 16'h00FF, 1'b0);
        rsp_sel  = 1'b0;
        rsp_data = 16'h1234;
        wait_idle();

        send(1'b0, 16'hAAAA, 1'b1);
        send(1'b0, 16'h5555, 1'b0);
        wait_idle();
        chk("b2b_gap", last_gap, 2);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(1'($urandom), 16'($urandom), 1'b0);
        end
        wait_idle();

        // Abandon a frame during a data bit of byte 2 (data high byte 0x00 keeps the line low)
        send(1'b1, 16'h00C3, 1'b0);
        repeat (24 * CPB) @(negedge clk);
        chk("pre_reset_line", oData, 0);
        #1 rst_n = 1'b0;
        #1 chk("reset_mid_frame", {oData, tx_active, rsp_ready, rsp_done}, 4'b1000);
        n_sent--;
        errs = 0;
        repeat (3) begin @(negedge clk); if (rsp_done !== 1'b0) errs++; end
        rst_n = 1'b1;
        repeat (10) begin @(negedge clk); if (rsp_done !== 1'b0 || oData !== 1'b1) errs++; end
        chk("no_done_after_abort", errs, 0);
        send(1'b0, 16'h0102, 1'b0);
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);

        solo(2, 2, 1'b1, 16'hA5C3);
        solo(3, 434, 1'b0, 16'hF128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
